spi_bus_bridge: RTL

//  Downstream of spi_data_path. Turns its address_ready/data_ready levels plus addr/status/wdata into

---
 rtl/spi_bus_bridge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_bus_bridge.sv
// Bridges spi_data_path address/data phase levels onto a single-outstanding req/ack register bus,
// with a 1-deep pending slot, burst address stepping, ack timeout and sticky error flags.
module spi_bus_bridge #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              address_ready,
    input  logic              data_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              cs_s1_q, cs_s2_q, cs_s3_q;
    logic              ar_q, dr_q;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;

    logic              frame_start, ar_p, dr_p;
    logic              rd_t, wr_t, br_t, trig, trig_we;
    logic [ADDR_W-1:0] trig_addr;
    logic              pend_live, pend_load;
    logic              unused_status;

    assign unused_status = ^{status[3], status[0]};

    assign frame_start = cs_s3_q & ~cs_s2_q;
    assign ar_p        = address_ready & ~ar_q;
    assign dr_p        = data_ready & ~dr_q;
    assign rd_t        = ar_p & ~status[2];
    assign wr_t        = dr_p & status[2];
    assign br_t        = dr_p & ~status[2] & status[1];
    assign trig        = rd_t | wr_t | br_t;
    assign trig_we     = wr_t;
    assign pend_live   = pend_q & ~frame_start;

    // Single writes always target addr; burst writes step by index, burst reads prefetch one ahead.
    always_comb begin
        trig_addr = addr;
        if (rd_t)
            trig_addr = addr;
        else if (wr_t)
            trig_addr = status[1] ? addr + idx_q : addr;
        else if (br_t)
            trig_addr = addr + idx_q + ADDR_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        pend_d        = pend_q;
        pend_load     = 1'b0;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q;

        if (frame_start) begin
            idx_d         = '0;
            pend_d        = 1'b0;
            err_timeout_d = 1'b0;
            err_overrun_d = 1'b0;
        end else if (wr_t || br_t) begin
            idx_d = idx_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pend_live) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = pend_we_q;
                    bus_addr_d  = pend_addr_q;
                    bus_wdata_d = pend_wdata_q;
                    pend_d      = 1'b0;
                    if (trig) begin
                        pend_d    = 1'b1;
                        pend_load = 1'b1;
                    end
                end else if (trig) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = trig_we;
                    bus_addr_d  = trig_addr;
                    bus_wdata_d = wdata;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q)
                        rdata_d = bus_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    bus_req_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    if (!bus_we_q)
                        rdata_d = ERR_DATA;
                end
                if (trig) begin
                    if (pend_live) begin
                        err_overrun_d = 1'b1;
                    end else begin
                        pend_d    = 1'b1;
                        pend_load = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_REQ) | pend_d;
    end

    always_comb begin
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        if (pend_load) begin
            pend_we_d    = trig_we;
            pend_addr_d  = trig_addr;
            pend_wdata_d = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cs_s1_q       <= 1'b1;
            cs_s2_q       <= 1'b1;
            cs_s3_q       <= 1'b1;
            ar_q          <= 1'b0;
            dr_q          <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_q        <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_s1_q       <= cs_n;
            cs_s2_q       <= cs_s1_q;
            cs_s3_q       <= cs_s2_q;
            ar_q          <= address_ready;
            dr_q          <= data_ready;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Pending payload is qualified by pend_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_we_q    <= pend_we_d;
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
    end

    assign rdata       = rdata_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule
